argon_memory_unit: RTL and testbench
====================================

Name: argon_memory_unit

Overview:
- Memory responder for the Argon core's 16-bit memory interface. It answers the core's address/read-enable/write-enable initiator port.
- Contains a word-organised RAM and a small MMIO register page: free-running cycle counter, GPIO output, and a W1C error status.
- Has a streaming program-loader port that fills RAM from word 0 while the core is halted.
- Clocked by the ungated system clock, never by the core's halt-gated clock.

Parameters:
- DEPTH, 4096, RAM size in 16-bit words. Byte range is 0x0000 to 2*DEPTH-1.
- MMIO_BASE, 16'hFF00, byte base address of the MMIO page.

Ports:
- i_clk  in  1  system clock (ungated)
- i_reset  in  1  synchronous, active-high reset
- i_memory_address  in  16  byte address from core
- i_memory_data  in  16  write data from core
- i_memory_re  in  1  read enable
- i_memory_we  in  1  write enable
- o_memory_data  out  16  read data, combinational, same cycle as address
- i_load_start  in  1  rewind load pointer to word 0
- i_load_valid  in  1  load word valid this cycle
- i_load_data  in  16  load word
- o_load_count  out  16  words written since last start
- o_gpio  out  16  GPIO output register
- o_status  out  4  sticky error bits

Behaviour:
- Reset (sync, i_reset high at posedge): o_gpio=0, o_status=0, cycle counter=0, load pointer=0, o_load_count=0. RAM contents are not reset.
- Address decode:
  - RAM hit when addr < 2*DEPTH; word index = addr>>1.
  - MMIO hits: MMIO_BASE+0 = counter (RO), +2 = GPIO (RW), +4 = status (read / W1C).
  - Any other address is out-of-range.
- Read (i_memory_re=1): o_memory_data is combinational from the current address and the current array/register state. This gives 0-cycle latency: the core samples it on the edge after it drives the address.
  - Returns 0 when re=0, addr[0]=1, or out-of-range.
  - Status reads return {12'b0, o_status}.
- Write (i_memory_we=1): takes effect at posedge.
  - RAM hit: word written.
  - GPIO: o_gpio <= data.
  - Status: o_status <= o_status & ~data[3:0].
  - Counter: write ignored.
- re and we both high: write performed at the edge; read returns pre-write value in that cycle.
- Error bits (sticky, set at posedge when the access is attempted):
  - [0] misaligned (re|we with addr[0]=1); the access is dropped.
  - [1] out-of-range (re|we); the access is dropped.
  - [2] load overflow.
  - [3] write conflict.
  - A set in the same cycle as a W1C clear: set wins.
- Cycle counter: +1 every cycle not in reset; wraps 0xFFFF->0x0000.
- Loader:
  - i_load_start=1: pointer and count <= 0; any i_load_valid that cycle is ignored.
  - i_load_valid=1 with pointer<DEPTH: RAM[pointer] <= i_load_data, pointer and count +1.
  - i_load_valid=1 with pointer==DEPTH: data dropped, status[2] set, pointer and count hold.
- Loader vs core write in the same cycle:
  - Same word: loader wins, core write dropped, status[3] set.
  - Different words: both writes complete.
- Core reads during loading are legal and see pre-edge contents.
- Reset mid-load: pointer and count cleared. Already-written RAM words are retained.

Test Plan:
- Load 0x1111, 0x2222, 0x3333 after start -> o_load_count=3; core reads at 0x0000/0x0002/0x0004 return 0x1111/0x2222/0x3333 in the same cycle.
- Core write 0xBEEF @0x0010 then read 0x0010 -> 0xBEEF. Same-cycle re+we 0x1234 @0x0010 -> read shows 0xBEEF; next cycle shows 0x1234.
- Read @0x0003 -> 0x0000, status=0001. Write 0xAAAA @0x4000 -> no RAM change, status=0011. Write 0x0001 @0xFF04 -> status=0010.
- Write 0x00A5 @0xFF02 -> o_gpio=0x00A5. Write @0xFF00 -> counter unaffected. Two reads of 0xFF00 10 cycles apart differ by 10. Counter is preloaded to 0xFFFE by running 65534 cycles after reset, and reads 0x0000 two cycles later.
- DEPTH=4: five loads -> RAM holds first four, status[2]=1, count=4. Loader and core both write word 1 -> loader data kept, status[3]=1.
- Assert i_reset after two loads -> count=0, gpio=0, status=0. Read @0x0000 still returns the first loaded word.

Source files
------------

// File: rtl/argon_memory_unit.sv
// Argon memory responder: word RAM, MMIO page (counter/GPIO/status)
// and a streaming program loader that fills RAM from word 0.
module argon_memory_unit #(
    parameter int          DEPTH     = 4096,
    parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_memory_address,
    input  logic [15:0] i_memory_data,
    input  logic        i_memory_re,
    input  logic        i_memory_we,
    output logic [15:0] o_memory_data,
    input  logic        i_load_start,
    input  logic        i_load_valid,
    input  logic [15:0] i_load_data,
    output logic [15:0] o_load_count,
    output logic [15:0] o_gpio,
    output logic [3:0]  o_status
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_counter;
    logic [15:0] r_gpio;
    logic [3:0]  r_status;
    logic [15:0] r_load_count;

    logic          w_access;
    logic          w_aligned;
    logic [15:0]   w_addr_even;
    logic          w_ram_hit;
    logic          w_cnt_hit;
    logic          w_gpio_hit;
    logic          w_st_hit;
    logic          w_in_range;
    logic [AW-1:0] w_word;
    logic          w_core_ram_wr;
    logic          w_ld_room;
    logic          w_ld_wr;
    logic          w_ld_ovf;
    logic [AW-1:0] w_ld_idx;
    logic          w_conflict;
    logic [3:0]    w_set;
    logic [3:0]    w_clr;
    logic [15:0]   w_rdata;

    // Address decode; range checks use the word-aligned address so a
    // misaligned access inside a valid region flags only misalignment.
    assign w_access    = i_memory_re | i_memory_we;
    assign w_aligned   = ~i_memory_address[0];
    assign w_addr_even = {i_memory_address[15:1], 1'b0};
    assign w_ram_hit   = {1'b0, w_addr_even} < 17'(2 * DEPTH);
    assign w_cnt_hit   = w_addr_even == MMIO_BASE;
    assign w_gpio_hit  = w_addr_even == (MMIO_BASE + 16'd2);
    assign w_st_hit    = w_addr_even == (MMIO_BASE + 16'd4);
    assign w_in_range  = w_ram_hit | w_cnt_hit | w_gpio_hit | w_st_hit;
    assign w_word      = i_memory_address[AW:1];

    // Loader: count doubles as the write pointer; start cancels valid.
    assign w_ld_room  = {1'b0, r_load_count} < 17'(DEPTH);
    assign w_ld_wr    = i_load_valid & ~i_load_start & w_ld_room;
    assign w_ld_ovf   = i_load_valid & ~i_load_start & ~w_ld_room;
    assign w_ld_idx   = r_load_count[AW-1:0];

    assign w_core_ram_wr = i_memory_we & w_aligned & w_ram_hit;
    assign w_conflict    = w_core_ram_wr & w_ld_wr & (w_word == w_ld_idx);

    assign w_set = {w_conflict,
                    w_ld_ovf,
                    w_access & ~w_in_range,
                    w_access & ~w_aligned};
    assign w_clr = (i_memory_we & w_aligned & w_st_hit) ?
                   i_memory_data[3:0] : 4'h0;

    // Zero-latency read mux from pre-edge state.
    always_comb begin
        w_rdata = 16'h0000;
        if (i_memory_re && w_aligned) begin
            if (w_ram_hit)
                w_rdata = r_mem[w_word];
            else if (w_cnt_hit)
                w_rdata = r_counter;
            else if (w_gpio_hit)
                w_rdata = r_gpio;
            else if (w_st_hit)
                w_rdata = {12'h000, r_status};
        end
    end

    // RAM writes; loader is applied last so it wins on a word clash.
    always_ff @(posedge i_clk) begin
        if (w_core_ram_wr && !w_conflict)
            r_mem[w_word] <= i_memory_data;
        if (w_ld_wr)
            r_mem[w_ld_idx] <= i_load_data;
    end

    // MMIO registers, loader count and free-running counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_counter    <= 16'h0000;
            r_gpio       <= 16'h0000;
            r_status     <= 4'h0;
            r_load_count <= 16'h0000;
        end else begin
            r_counter <= r_counter + 16'd1;
            r_status  <= (r_status & ~w_clr) | w_set;
            if (i_memory_we && w_aligned && w_gpio_hit)
                r_gpio <= i_memory_data;
            if (i_load_start)
                r_load_count <= 16'h0000;
            else if (w_ld_wr)
                r_load_count <= r_load_count + 16'd1;
        end
    end

    assign o_memory_data = w_rdata;
    assign o_load_count  = r_load_count;
    assign o_gpio        = r_gpio;
    assign o_status      = r_status;

endmodule

// File: tb/tb_argon_memory_unit.sv
// Directed bench for argon_memory_unit: a full-size instance and a
// DEPTH=4 instance for loader overflow and conflict cases.
module tb_argon_memory_unit;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] addr, wdata, rdata, ld_data, ld_count, gpio;
    logic        re, we, ld_start, ld_valid;
    logic [3:0]  status;

    logic [15:0] s_addr, s_wdata, s_rdata, s_ld_data, s_ld_count, s_gpio;
    logic        s_re, s_we, s_ld_start, s_ld_valid;
    logic [3:0]  s_status;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    argon_memory_unit u_dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_memory_address (addr),
        .i_memory_data    (wdata),
        .i_memory_re      (re),
        .i_memory_we      (we),
        .o_memory_data    (rdata),
        .i_load_start     (ld_start),
        .i_load_valid     (ld_valid),
        .i_load_data      (ld_data),
        .o_load_count     (ld_count),
        .o_gpio           (gpio),
        .o_status         (status)
    );

    argon_memory_unit #(.DEPTH(4)) u_small (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_memory_address (s_addr),
        .i_memory_data    (s_wdata),
        .i_memory_re      (s_re),
        .i_memory_we      (s_we),
        .o_memory_data    (s_rdata),
        .i_load_start     (s_ld_start),
        .i_load_valid     (s_ld_valid),
        .i_load_data      (s_ld_data),
        .o_load_count     (s_ld_count),
        .o_gpio           (s_gpio),
        .o_status         (s_status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mw(input logic [15:0] a, input logic [15:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic sw(input logic [15:0] a, input logic [15:0] d);
        s_addr = a; s_wdata = d; s_we = 1'b1;
        tick();
        s_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        re = 1'b1; addr = 16'hFF00;
        #1;
        n_total++;
        if (rdata !== 16'h0000) $display("FAIL reset_counter got %h want 0000", rdata);
        else n_pass++;
        n_total++;
        if (gpio !== 16'h0000) $display("FAIL reset_gpio got %h want 0000", gpio);
        else n_pass++;
        n_total++;
        if (status !== 4'h0) $display("FAIL reset_status got %h want 0", status);
        else n_pass++;
        n_total++;
        if (ld_count !== 16'h0000) $display("FAIL reset_count got %h want 0000", ld_count);
        else n_pass++;
        re = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_load();
        logic [15:0] exp [3];
        exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = exp[i];
            tick();
        end
        ld_valid = 1'b0;
        n_total++;
        if (ld_count !== 16'd3) $display("FAIL load_count got %h want 0003", ld_count);
        else n_pass++;
        re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 16'(2 * i);
            #1;
            n_total++;
            if (rdata !== exp[i])
                $display("FAIL load_read%0d got %h want %h", i, rdata, exp[i]);
            else n_pass++;
        end
        re = 1'b0;
    endtask

    task automatic test_rw();
        mw(16'h0010, 16'hBEEF);
        re = 1'b1; addr = 16'h0010;
        #1;
        n_total++;
        if (rdata !== 16'hBEEF) $display("FAIL rw_read got %h want beef", rdata);
        else n_pass++;
        wdata = 16'h1234; we = 1'b1;
        #1;
        n_total++;
        if (rdata !== 16'hBEEF) $display("FAIL rw_same_cycle got %h want beef", rdata);
        else n_pass++;
        tick();
        we = 1'b0;
        #1;
        n_total++;
        if (rdata !== 16'h1234) $display("FAIL rw_next_cycle got %h want 1234", rdata);
        else n_pass++;
        re = 1'b0;
    endtask

    task automatic test_errors();
        re = 1'b1; addr = 16'h0003;
        #1;
        n_total++;
        if (rdata !== 16'h0000) $display("FAIL misalign_read got %h want 0000", rdata);
        else n_pass++;
        tick();
        re = 1'b0;
        n_total++;
        if (status !== 4'b0001) $display("FAIL misalign_status got %b want 0001", status);
        else n_pass++;
        mw(16'h4000, 16'hAAAA);
        n_total++;
        if (status !== 4'b0011) $display("FAIL oor_status got %b want 0011", status);
        else n_pass++;
        re = 1'b1; addr = 16'h0000;
        #1;
        n_total++;
        if (rdata !== 16'h1111) $display("FAIL oor_no_alias got %h want 1111", rdata);
        else n_pass++;
        re = 1'b0;
        mw(16'hFF04, 16'h0001);
        n_total++;
        if (status !== 4'b0010) $display("FAIL w1c_status got %b want 0010", status);
        else n_pass++;
        re = 1'b1; addr = 16'hFF04;
        #1;
        n_total++;
        if (rdata !== 16'h0002) $display("FAIL status_read got %h want 0002", rdata);
        else n_pass++;
        re = 1'b0;
    endtask

    task automatic test_gpio();
        mw(16'hFF02, 16'h00A5);
        n_total++;
        if (gpio !== 16'h00A5) $display("FAIL gpio_out got %h want 00a5", gpio);
        else n_pass++;
        re = 1'b1; addr = 16'hFF02;
        #1;
        n_total++;
        if (rdata !== 16'h00A5) $display("FAIL gpio_read got %h want 00a5", rdata);
        else n_pass++;
        re = 1'b0;
    endtask

    task automatic test_counter();
        logic [15:0] a;
        logic [15:0] c;
        re = 1'b1; addr = 16'hFF00;
        #1;
        a = rdata;
        wdata = 16'h0000; we = 1'b1;
        tick();
        we = 1'b0;
        n_total++;
        if (rdata !== a + 16'd1)
            $display("FAIL counter_ro got %h want %h", rdata, a + 16'd1);
        else n_pass++;
        c = rdata;
        repeat (10) tick();
        n_total++;
        if (rdata !== c + 16'd10)
            $display("FAIL counter_delta got %h want %h", rdata, c + 16'd10);
        else n_pass++;
        re = 1'b0;
    endtask

    task automatic test_small_overflow();
        s_ld_start = 1'b1;
        tick();
        s_ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_ld_valid = 1'b1; s_ld_data = 16'hA000 + 16'(i);
            tick();
        end
        s_ld_valid = 1'b0;
        n_total++;
        if (s_ld_count !== 16'd4) $display("FAIL ovf_count got %h want 0004", s_ld_count);
        else n_pass++;
        n_total++;
        if (s_status !== 4'b0100) $display("FAIL ovf_status got %b want 0100", s_status);
        else n_pass++;
        s_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_addr = 16'(2 * i);
            #1;
            n_total++;
            if (s_rdata !== 16'hA000 + 16'(i))
                $display("FAIL ovf_word%0d got %h want %h", i, s_rdata, 16'hA000 + 16'(i));
            else n_pass++;
        end
        s_re = 1'b0;
        s_ld_valid = 1'b1; s_ld_data = 16'hFFFF;
        s_addr = 16'hFF04; s_wdata = 16'h0004; s_we = 1'b1;
        tick();
        s_ld_valid = 1'b0; s_we = 1'b0;
        n_total++;
        if (s_status !== 4'b0100) $display("FAIL set_wins got %b want 0100", s_status);
        else n_pass++;
    endtask

    task automatic test_small_conflict();
        s_ld_start = 1'b1;
        tick();
        s_ld_start = 1'b0;
        s_ld_valid = 1'b1; s_ld_data = 16'hD000;
        tick();
        s_ld_data = 16'h5555;
        s_addr = 16'h0002; s_wdata = 16'h6666; s_we = 1'b1;
        tick();
        s_ld_valid = 1'b0; s_we = 1'b0;
        n_total++;
        if (s_status !== 4'b1100) $display("FAIL conflict_status got %b want 1100", s_status);
        else n_pass++;
        s_re = 1'b1; s_addr = 16'h0002;
        #1;
        n_total++;
        if (s_rdata !== 16'h5555) $display("FAIL conflict_word got %h want 5555", s_rdata);
        else n_pass++;
        s_re = 1'b0;
        sw(16'hFF04, 16'h000F);
        n_total++;
        if (s_status !== 4'b0000) $display("FAIL w1c_all got %b want 0000", s_status);
        else n_pass++;
        s_ld_valid = 1'b1; s_ld_data = 16'h7777;
        s_addr = 16'h0006; s_wdata = 16'h8888; s_we = 1'b1;
        tick();
        s_ld_valid = 1'b0; s_we = 1'b0;
        s_re = 1'b1; s_addr = 16'h0004;
        #1;
        n_total++;
        if (s_rdata !== 16'h7777) $display("FAIL dual_load_word got %h want 7777", s_rdata);
        else n_pass++;
        s_addr = 16'h0006;
        #1;
        n_total++;
        if (s_rdata !== 16'h8888) $display("FAIL dual_core_word got %h want 8888", s_rdata);
        else n_pass++;
        s_re = 1'b0;
        n_total++;
        if (s_status !== 4'b0000 || s_ld_count !== 16'd3)
            $display("FAIL dual_state got status %b count %h want 0000 0003", s_status, s_ld_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        sw(16'hFF02, 16'h003C);
        s_ld_start = 1'b1;
        tick();
        s_ld_start = 1'b0;
        s_ld_valid = 1'b1; s_ld_data = 16'hC001;
        tick();
        s_ld_data = 16'hC002;
        tick();
        s_ld_valid = 1'b0;
        n_total++;
        if (s_ld_count !== 16'd2 || s_gpio !== 16'h003C)
            $display("FAIL pre_reset got count %h gpio %h want 0002 003c", s_ld_count, s_gpio);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (s_ld_count !== 16'd0 || s_gpio !== 16'd0 || s_status !== 4'd0)
            $display("FAIL mid_reset got count %h gpio %h status %b want 0 0 0",
                     s_ld_count, s_gpio, s_status);
        else n_pass++;
        s_re = 1'b1; s_addr = 16'h0000;
        #1;
        n_total++;
        if (s_rdata !== 16'hC001) $display("FAIL ram_retained got %h want c001", s_rdata);
        else n_pass++;
        s_re = 1'b0;
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (65534) tick();
        re = 1'b1; addr = 16'hFF00;
        #1;
        n_total++;
        if (rdata !== 16'hFFFE) $display("FAIL wrap_pre got %h want fffe", rdata);
        else n_pass++;
        repeat (2) tick();
        n_total++;
        if (rdata !== 16'h0000) $display("FAIL wrap_post got %h want 0000", rdata);
        else n_pass++;
        re = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        addr = '0; wdata = '0; re = 1'b0; we = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        s_addr = '0; s_wdata = '0; s_re = 1'b0; s_we = 1'b0;
        s_ld_start = 1'b0; s_ld_valid = 1'b0; s_ld_data = '0;
        repeat (2) tick();
        test_reset();
        test_load();
        test_rw();
        test_errors();
        test_gpio();
        test_counter();
        test_small_overflow();
        test_small_conflict();
        test_reset_mid_load();
        test_counter_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
